multi_hart_arb: RTL and testbench

MULTI_HART_ARB -- requirements
Module: multi_hart_arb

---
 rtl/multi_hart_arb.sv | 237 +++++++++++++++++++++++
 tb/tb_multi_hart_arb.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_hart_arb.sv
// multi_hart_arb: round-robin arbiter that shares one memory port between
// NHARTS harts, with an optional LR/SC reservation table.
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   w_req/w_we/w_lr/w_sc  per-hart request and qualifiers (held until done)
//   w_addr                per-hart address, hart i at [i*ADDR_W +: ADDR_W]
//   w_done                one-cycle completion pulse for the granted hart
//   w_grant/w_grant_id    registered one-hot grant and granted hart index
//   w_busy                high while a grant is outstanding
//   w_sc_fail             one-cycle pulse: that hart's SC failed, no access
//   w_resv_valid          per-hart reservation-valid flags
//
// Build option: define LRSC_RESV_EN to enable the reservation table and the
// SC check. Without it, SC behaves as a plain store, LR as a plain load, and
// w_sc_fail / w_resv_valid are tied low.
module multi_hart_arb #(
    parameter int unsigned NHARTS   = 2,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned GRAN_LSB = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NHARTS-1:0]        w_req,
    input  logic [NHARTS-1:0]        w_we,
    input  logic [NHARTS-1:0]        w_lr,
    input  logic [NHARTS-1:0]        w_sc,
    input  logic [NHARTS*ADDR_W-1:0] w_addr,
    input  logic                     w_done,
    output logic [NHARTS-1:0]        w_grant,
    output logic [2:0]               w_grant_id,
    output logic                     w_busy,
    output logic [NHARTS-1:0]        w_sc_fail,
    output logic [NHARTS-1:0]        w_resv_valid
);

    localparam int unsigned ID_W = 3;
    localparam int unsigned GW   = ADDR_W - GRAN_LSB;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        SCFAIL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NHARTS-1:0] grant_q, grant_d;
    logic [NHARTS-1:0] sc_fail_q, sc_fail_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic              busy_q, busy_d;

    logic              found;
    logic [NHARTS-1:0] sel_oh;
    logic [ID_W-1:0]   sel;

    // Qualifiers are only consumed by the reservation logic; keep lint quiet
    // in the build where that logic is absent.
    logic unused_ok;
    assign unused_ok = ^{w_we, w_lr, w_sc, w_addr};

`ifdef LRSC_RESV_EN
    logic [NHARTS-1:0] resv_valid_q, resv_valid_d;
    logic [GW-1:0]     resv_addr_q [NHARTS];
    logic [GW-1:0]     resv_addr_d [NHARTS];
    logic [GW-1:0]     gran [NHARTS];
    logic [GW-1:0]     sel_gran;
    logic              sel_we, sel_lr, sel_sc, sel_resv_hit;

    // Reservation granule of each hart's current address
    for (genvar g = 0; g < NHARTS; g++) begin : g_gran
        assign gran[g] = w_addr[g*ADDR_W + GRAN_LSB +: GW];
    end

    // Attributes of the selected hart, gathered through the one-hot select
    always_comb begin
        sel_gran     = '0;
        sel_resv_hit = 1'b0;
        for (int unsigned j = 0; j < NHARTS; j++) begin
            if (sel_oh[j]) begin
                sel_gran = gran[j];
            end
        end
        for (int unsigned j = 0; j < NHARTS; j++) begin
            if (sel_oh[j] && resv_valid_q[j] && (resv_addr_q[j] == sel_gran)) begin
                sel_resv_hit = 1'b1;
            end
        end
        sel_we = |(w_we & sel_oh);
        sel_lr = |(w_lr & sel_oh);
        sel_sc = |(w_sc & sel_oh);
    end
`endif

    // Round-robin pick: first requester at or after last_id+1, wrapping at NHARTS
    always_comb begin : rr_select
        int unsigned idx;
        idx    = 0;
        found  = 1'b0;
        sel_oh = '0;
        sel    = '0;
        for (int unsigned k = 1; k <= NHARTS; k++) begin
            idx = 32'(last_q) + k;
            if (idx >= NHARTS) begin
                idx = idx - NHARTS;
            end
            for (int unsigned j = 0; j < NHARTS; j++) begin
                if (!found && (idx == j) && w_req[j]) begin
                    found     = 1'b1;
                    sel_oh[j] = 1'b1;
                    sel       = ID_W'(j);
                end
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        id_d      = id_q;
        busy_d    = busy_q;
        last_d    = last_q;
        sc_fail_d = '0;
`ifdef LRSC_RESV_EN
        resv_valid_d = resv_valid_q;
        resv_addr_d  = resv_addr_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    last_d = sel;
                    id_d   = sel;
`ifdef LRSC_RESV_EN
                    if (sel_sc && !sel_resv_hit) begin
                        state_d      = SCFAIL;
                        grant_d      = '0;
                        busy_d       = 1'b0;
                        sc_fail_d    = sel_oh;
                        resv_valid_d = resv_valid_q & ~sel_oh;
                    end else begin
                        state_d = GRANT;
                        grant_d = sel_oh;
                        busy_d  = 1'b1;
                        // A store to a granule kills every reservation on it
                        if (sel_we || sel_sc) begin
                            for (int unsigned j = 0; j < NHARTS; j++) begin
                                if (resv_addr_q[j] == sel_gran) begin
                                    resv_valid_d[j] = 1'b0;
                                end
                            end
                        end
                        if (sel_sc) begin
                            resv_valid_d = resv_valid_d & ~sel_oh;
                        end
                        if (sel_lr) begin
                            for (int unsigned j = 0; j < NHARTS; j++) begin
                                if (sel_oh[j]) begin
                                    resv_addr_d[j]  = sel_gran;
                                    resv_valid_d[j] = 1'b1;
                                end
                            end
                        end
                    end
`else
                    state_d = GRANT;
                    grant_d = sel_oh;
                    busy_d  = 1'b1;
`endif
                end
            end
            GRANT: begin
                if (w_done) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end
            end
            SCFAIL: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            id_q      <= '0;
            busy_q    <= 1'b0;
            sc_fail_q <= '0;
            last_q    <= ID_W'(NHARTS - 1);
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            busy_q    <= busy_d;
            sc_fail_q <= sc_fail_d;
            last_q    <= last_d;
        end
    end

`ifdef LRSC_RESV_EN
    // Reservation table
    always_ff @(posedge CLK) begin
        if (RST) begin
            resv_valid_q <= '0;
            for (int unsigned j = 0; j < NHARTS; j++) begin
                resv_addr_q[j] <= '0;
            end
        end else begin
            resv_valid_q <= resv_valid_d;
            for (int unsigned j = 0; j < NHARTS; j++) begin
                resv_addr_q[j] <= resv_addr_d[j];
            end
        end
    end

    assign w_resv_valid = resv_valid_q;
`else
    assign w_resv_valid = '0;
`endif

    assign w_grant    = grant_q;
    assign w_grant_id = id_q;
    assign w_busy     = busy_q;
    assign w_sc_fail  = sc_fail_q;

endmodule

// File: tb/tb_multi_hart_arb.sv
// Testbench for multi_hart_arb: a 2-hart instance for arbitration and LR/SC
// behaviour, and a 3-hart instance for non-power-of-two round-robin and reset.
module tb_multi_hart_arb;

    localparam int unsigned AW = 32;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    // 2-hart instance
    logic [1:0]    req2 = '0, we2 = '0, lr2 = '0, sc2 = '0;
    logic [2*AW-1:0] addr2 = '0;
    logic          done2 = 1'b0;
    logic [1:0]    grant2, fail2, resv2;
    logic [2:0]    id2;
    logic          busy2;

    // 3-hart instance
    logic [2:0]    req3 = '0, we3 = '0, lr3 = '0, sc3 = '0;
    logic [3*AW-1:0] addr3 = '0;
    logic          done3 = 1'b0;
    logic [2:0]    grant3, fail3, resv3;
    logic [2:0]    id3;
    logic          busy3;

    multi_hart_arb #(.NHARTS(2), .ADDR_W(AW), .GRAN_LSB(2)) u_dut2 (
        .CLK(CLK), .RST(RST),
        .w_req(req2), .w_we(we2), .w_lr(lr2), .w_sc(sc2), .w_addr(addr2),
        .w_done(done2),
        .w_grant(grant2), .w_grant_id(id2), .w_busy(busy2),
        .w_sc_fail(fail2), .w_resv_valid(resv2)
    );

    multi_hart_arb #(.NHARTS(3), .ADDR_W(AW), .GRAN_LSB(2)) u_dut3 (
        .CLK(CLK), .RST(RST),
        .w_req(req3), .w_we(we3), .w_lr(lr3), .w_sc(sc3), .w_addr(addr3),
        .w_done(done3),
        .w_grant(grant3), .w_grant_id(id3), .w_busy(busy3),
        .w_sc_fail(fail3), .w_resv_valid(resv3)
    );

    typedef struct packed {
        logic [1:0] grant;
        logic [1:0] fail;
    } exp_t;

    exp_t        sb2[$];
    int unsigned sb_id[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One complete transaction on the 2-hart instance
    task automatic run_txn(input int hart, input logic we, input logic lr,
                           input logic sc, input logic [31:0] addr,
                           input logic exp_fail, input string name);
        exp_t       e;
        logic [1:0] oh;
        oh  = 2'b01 << hart;
        req2 = oh;
        we2 = we ? oh : 2'b00;
        lr2 = lr ? oh : 2'b00;
        sc2 = sc ? oh : 2'b00;
        addr2[hart*AW +: AW] = addr;
        e.grant = exp_fail ? 2'b00 : oh;
        e.fail  = exp_fail ? oh : 2'b00;
        sb2.push_back(e);
        tick();
        e = sb2.pop_front();
        n_checks++;
        if (grant2 !== e.grant) begin
            n_fail++;
            $display("FAIL %s grant: got %b expected %b", name, grant2, e.grant);
        end
        n_checks++;
        if (fail2 !== e.fail) begin
            n_fail++;
            $display("FAIL %s sc_fail: got %b expected %b", name, fail2, e.fail);
        end
        req2 = 2'b00; we2 = 2'b00; lr2 = 2'b00; sc2 = 2'b00;
        if (!exp_fail) begin
            done2 = 1'b1;
            tick();
            done2 = 1'b0;
        end else begin
            tick();
        end
        n_checks++;
        if (grant2 !== 2'b00 || fail2 !== 2'b00 || busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s release: grant=%b sc_fail=%b busy=%b expected 00/00/0",
                     name, grant2, fail2, busy2);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({grant2, id2, busy2, fail2, resv2} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_dut2: grant=%b id=%0d busy=%b sc_fail=%b resv=%b expected all 0",
                     grant2, id2, busy2, fail2, resv2);
        end
        n_checks++;
        if ({grant3, id3, busy3, fail3, resv3} !== 13'b0) begin
            n_fail++;
            $display("FAIL reset_dut3: grant=%b id=%0d busy=%b expected all 0", grant3, id3, busy3);
        end
        RST = 1'b0;
    endtask

    // Both harts request continuously: 0,1,0 with one idle cycle between grants
    task automatic test_round_robin();
        int unsigned h;
        sb_id.push_back(0);
        sb_id.push_back(1);
        sb_id.push_back(0);
        req2 = 2'b11;
        for (int n = 0; n < 3; n++) begin
            h = sb_id.pop_front();
            tick();
            n_checks++;
            if (grant2 !== (2'b01 << h) || id2 !== 3'(h) || busy2 !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_grant%0d: grant=%b id=%0d busy=%b expected grant=%b id=%0d busy=1",
                         n, grant2, id2, busy2, 2'b01 << h, h);
            end
            done2 = 1'b1;
            tick();
            done2 = 1'b0;
            n_checks++;
            if (grant2 !== 2'b00 || busy2 !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_idle%0d: grant=%b busy=%b expected 00/0", n, grant2, busy2);
            end
        end
        req2 = 2'b00;
        tick();
    endtask

    // done in IDLE is ignored; grant held until done even if req drops
    task automatic test_hold();
        done2 = 1'b1;
        tick();
        done2 = 1'b0;
        n_checks++;
        if (grant2 !== 2'b00 || busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_done: grant=%b busy=%b expected 00/0", grant2, busy2);
        end
        req2 = 2'b01;
        tick();
        n_checks++;
        if (grant2 !== 2'b01) begin
            n_fail++;
            $display("FAIL hold_grant: grant=%b expected 01", grant2);
        end
        req2 = 2'b00;
        tick();
        tick();
        n_checks++;
        if (grant2 !== 2'b01 || busy2 !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_nodone: grant=%b busy=%b expected 01/1", grant2, busy2);
        end
        done2 = 1'b1;
        tick();
        done2 = 1'b0;
        n_checks++;
        if (grant2 !== 2'b00 || busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: grant=%b busy=%b expected 00/0", grant2, busy2);
        end
    endtask

`ifdef LRSC_RESV_EN
    task automatic test_lrsc();
        run_txn(0, 1'b0, 1'b1, 1'b0, 32'h8000_1000, 1'b0, "lr0");
        n_checks++;
        if (resv2 !== 2'b01) begin
            n_fail++;
            $display("FAIL lr0_resv: got %b expected 01", resv2);
        end
        run_txn(0, 1'b0, 1'b0, 1'b1, 32'h8000_1000, 1'b0, "sc0_ok");
        n_checks++;
        if (resv2 !== 2'b00) begin
            n_fail++;
            $display("FAIL sc0_ok_resv: got %b expected 00", resv2);
        end
        run_txn(0, 1'b0, 1'b1, 1'b0, 32'h8000_1000, 1'b0, "lr0b");
        run_txn(1, 1'b1, 1'b0, 1'b0, 32'h8000_1002, 1'b0, "st1_kill");
        n_checks++;
        if (resv2 !== 2'b00) begin
            n_fail++;
            $display("FAIL st1_kill_resv: got %b expected 00", resv2);
        end
        run_txn(0, 1'b0, 1'b0, 1'b1, 32'h8000_1000, 1'b1, "sc0_fail");
        run_txn(1, 1'b0, 1'b1, 1'b0, 32'h8000_2000, 1'b0, "lr1");
        run_txn(0, 1'b1, 1'b0, 1'b0, 32'h8000_2004, 1'b0, "st0_other");
        n_checks++;
        if (resv2 !== 2'b10) begin
            n_fail++;
            $display("FAIL st0_other_resv: got %b expected 10", resv2);
        end
    endtask
`else
    task automatic test_sc_plain();
        run_txn(1, 1'b0, 1'b0, 1'b1, 32'h8000_3000, 1'b0, "sc1_noresv");
        run_txn(0, 1'b0, 1'b1, 1'b0, 32'h8000_1000, 1'b0, "lr0_plain");
        n_checks++;
        if (resv2 !== 2'b00) begin
            n_fail++;
            $display("FAIL lr0_plain_resv: got %b expected 00", resv2);
        end
        run_txn(0, 1'b0, 1'b0, 1'b1, 32'h8000_1000, 1'b0, "sc0_plain");
    endtask
`endif

    // 3 harts always requesting: 0,1,2,0; reset during the last grant
    task automatic test_nharts3();
        int unsigned h;
        int          waited;
        for (int n = 0; n < 4; n++) begin
            sb_id.push_back(n % 3);
        end
        req3 = 3'b111;
        for (int n = 0; n < 4; n++) begin
            waited = 0;
            do begin
                tick();
                waited++;
            end while (grant3 === 3'b000 && waited < 6);
            h = sb_id.pop_front();
            n_checks++;
            if (grant3 !== (3'b001 << h) || id3 !== 3'(h) || waited != 1) begin
                n_fail++;
                $display("FAIL n3_grant%0d: grant=%b id=%0d after %0d cycles expected grant=%b id=%0d after 1",
                         n, grant3, id3, waited, 3'b001 << h, h);
            end
            if (n < 3) begin
                done3 = 1'b1;
                tick();
                done3 = 1'b0;
            end
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        req3 = 3'b000;
        n_checks++;
        if (grant3 !== 3'b000 || busy3 !== 1'b0) begin
            n_fail++;
            $display("FAIL n3_reset_drop: grant=%b busy=%b expected 000/0", grant3, busy3);
        end
        done3 = 1'b1;
        tick();
        done3 = 1'b0;
        tick();
        n_checks++;
        if (grant3 !== 3'b000 || busy3 !== 1'b0) begin
            n_fail++;
            $display("FAIL n3_post_reset: grant=%b busy=%b expected 000/0", grant3, busy3);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_hold();
`ifdef LRSC_RESV_EN
        test_lrsc();
`else
        test_sc_plain();
`endif
        test_nharts3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
